// File: rtl/duck_pkg.sv
// Shared types, direction encodings and sprite frame map for the duck flight engine.
package duck_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StFly,
        StShot,
        StFall,
        StEscape,
        StDone
    } duck_state_t;

    typedef enum logic [1:0] {
        ColBlack  = 2'd0,
        ColBlue   = 2'd1,
        ColRed    = 2'd2,
        ColUnused = 2'd3
    } duck_color_t;

    // Rand_dir values as delivered by the random source.
    localparam logic [1:0] DirNw = 2'd0;
    localparam logic [1:0] DirW  = 2'd1;
    localparam logic [1:0] DirNe = 2'd2;
    localparam logic [1:0] DirE  = 2'd3;

    localparam logic HRight = 1'b0;
    localparam logic HLeft  = 1'b1;
    localparam logic VUp    = 1'b0;
    localparam logic VDown  = 1'b1;

    // Sprite sheet layout: each colour owns a block of ColorStride frames.
    localparam logic [5:0] BaseNe      = 6'd0;
    localparam logic [5:0] BaseE       = 6'd4;
    localparam logic [5:0] BaseShot    = 6'd8;
    localparam logic [5:0] BaseFall    = 6'd9;
    localparam logic [5:0] BaseNw      = 6'd11;
    localparam logic [5:0] BaseW       = 6'd15;
    localparam logic [5:0] ColorStride = 6'd20;

    // Sprite index for a duck given its state, colour, heading and animation phase.
    function automatic logic [5:0] frame_of(
        input duck_state_t st,
        input duck_color_t col,
        input logic        h,
        input logic        shallow,
        input logic [3:0]  flap,
        input logic        fall_alt
    );
        logic [5:0] base;
        case (st)
            StFly: begin
                if (h == HLeft) base = shallow ? BaseW : BaseNw;
                else            base = shallow ? BaseE : BaseNe;
                base = base + 6'(flap);
            end
            StEscape: base = ((h == HLeft) ? BaseNw : BaseNe) + 6'(flap);
            StShot:   base = BaseShot;
            StFall:   base = BaseFall + 6'(fall_alt);
            default:  base = 6'd0;
        endcase
        return 6'(col) * ColorStride + base;
    endfunction

endpackage

// File: rtl/duck_flight_fsm.sv
// One duck channel: launch, bouncing flight, shot/fall and escape sequencing.
module duck_flight_fsm
    import duck_pkg::*;
#(
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 608,
    parameter int unsigned Y_MIN       = 16,
    parameter int unsigned Y_START     = 300,
    parameter int unsigned STEP_LG     = 4,
    parameter int unsigned STEP_SM     = 2,
    parameter int unsigned FALL_STEP   = 6,
    parameter int unsigned FLAP_FRAMES = 3,
    parameter int unsigned FLY_TICKS   = 64,
    parameter int unsigned SHOT_TICKS  = 5
) (
    input  logic       ANIM_Clk,
    input  logic       Reset,
    input  logic       launch,
    input  logic       hit,
    input  logic [9:0] rand_x,
    input  logic [1:0] rand_dir,
    input  logic [1:0] rand_color,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [5:0] frame,
    output logic [1:0] color,
    output logic       active,
    output logic       escaped,
    output logic       shot_down
);

    // Signed 11-bit copies so next positions can go below zero before clamping.
    localparam logic signed [10:0] XMin     = 11'(X_MIN);
    localparam logic signed [10:0] XMax     = 11'(X_MAX);
    localparam logic signed [10:0] YMin     = 11'(Y_MIN);
    localparam logic signed [10:0] YStart   = 11'(Y_START);
    localparam logic signed [10:0] StepLg   = 11'(STEP_LG);
    localparam logic signed [10:0] StepSm   = 11'(STEP_SM);
    localparam logic signed [10:0] FallStep = 11'(FALL_STEP);
    localparam logic [15:0]        FlyLast  = 16'(FLY_TICKS - 1);
    localparam logic [15:0]        ShotLast = 16'(SHOT_TICKS - 1);
    localparam logic [3:0]         FlapLast = 4'(FLAP_FRAMES - 1);

    duck_state_t state_q, state_d;
    duck_color_t color_q, color_d;
    logic [9:0]  x_q, x_d, y_q, y_d, x_launch;
    logic        h_q, h_d, v_q, v_d, shallow_q, shallow_d;
    logic [3:0]  flap_q, flap_d, flap_inc;
    logic        fall_alt_q, fall_alt_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  frame_q, frame_d;
    logic        escaped_q, escaped_d, shot_down_q, shot_down_d;

    logic signed [10:0] x_cur, y_cur, y_step, x_nx, y_nx, y_fall;

    // Next-state, motion, bounce and frame selection.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        h_d         = h_q;
        v_d         = v_q;
        shallow_d   = shallow_q;
        color_d     = color_q;
        flap_d      = flap_q;
        fall_alt_d  = fall_alt_q;
        cnt_d       = cnt_q;
        escaped_d   = 1'b0;
        shot_down_d = 1'b0;

        x_cur    = {1'b0, x_q};
        y_cur    = {1'b0, y_q};
        y_step   = shallow_q ? StepSm : StepLg;
        x_nx     = (h_q == HLeft) ? x_cur - StepLg : x_cur + StepLg;
        y_nx     = (v_q == VDown) ? y_cur + y_step : y_cur - y_step;
        y_fall   = y_cur + FallStep;
        flap_inc = (flap_q == FlapLast) ? 4'd0 : flap_q + 4'd1;

        if (rand_x > 10'(X_MAX))      x_launch = 10'(X_MAX);
        else if (rand_x < 10'(X_MIN)) x_launch = 10'(X_MIN);
        else                          x_launch = rand_x;

        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    state_d   = StLaunch;
                    x_d       = x_launch;
                    y_d       = 10'(Y_START);
                    h_d       = (rand_dir == DirNw || rand_dir == DirW) ? HLeft : HRight;
                    shallow_d = (rand_dir == DirW || rand_dir == DirE);
                    v_d       = VUp;
                    color_d   = (rand_color == ColUnused) ? ColBlack : duck_color_t'(rand_color);
                end
            end
            StLaunch: begin
                state_d = StFly;
                cnt_d   = '0;
                flap_d  = '0;
            end
            StFly: begin
                if (hit) begin
                    // Position freezes on the hit tick; the shot pose shows immediately.
                    state_d = StShot;
                    cnt_d   = '0;
                end else begin
                    if (x_nx < XMin) begin
                        x_d = 10'(X_MIN);
                        h_d = ~h_q;
                    end else if (x_nx > XMax) begin
                        x_d = 10'(X_MAX);
                        h_d = ~h_q;
                    end else begin
                        x_d = x_nx[9:0];
                    end
                    if (y_nx < YMin) begin
                        y_d = 10'(Y_MIN);
                        v_d = VDown;
                    end else if (y_nx > YStart) begin
                        y_d = 10'(Y_START);
                        v_d = VUp;
                    end else begin
                        y_d = y_nx[9:0];
                    end
                    if (cnt_q == FlyLast) begin
                        state_d = StEscape;
                        flap_d  = '0;
                    end else begin
                        cnt_d  = cnt_q + 16'd1;
                        flap_d = flap_inc;
                    end
                end
            end
            StShot: begin
                if (cnt_q == ShotLast) begin
                    state_d    = StFall;
                    fall_alt_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StFall: begin
                if (y_fall >= YStart) begin
                    y_d         = 10'(Y_START);
                    state_d     = StDone;
                    shot_down_d = 1'b1;
                end else begin
                    y_d        = y_fall[9:0];
                    fall_alt_d = ~fall_alt_q;
                end
            end
            StEscape: begin
                if (y_q < 10'(STEP_LG)) begin
                    state_d   = StDone;
                    escaped_d = 1'b1;
                end else begin
                    y_d    = y_q - 10'(STEP_LG);
                    flap_d = flap_inc;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        frame_d = frame_of(state_d, color_d, h_d, shallow_d, flap_d, fall_alt_d);
    end

    // Channel state register with asynchronous reset.
    always_ff @(posedge ANIM_Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            x_q         <= 10'(X_MIN);
            y_q         <= 10'(Y_START);
            h_q         <= HRight;
            v_q         <= VUp;
            shallow_q   <= 1'b0;
            color_q     <= ColBlack;
            flap_q      <= '0;
            fall_alt_q  <= 1'b0;
            cnt_q       <= '0;
            frame_q     <= '0;
            escaped_q   <= 1'b0;
            shot_down_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            h_q         <= h_d;
            v_q         <= v_d;
            shallow_q   <= shallow_d;
            color_q     <= color_d;
            flap_q      <= flap_d;
            fall_alt_q  <= fall_alt_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            escaped_q   <= escaped_d;
            shot_down_q <= shot_down_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign frame     = frame_q;
    assign color     = color_q;
    assign active    = (state_q != StIdle);
    assign escaped   = escaped_q;
    assign shot_down = shot_down_q;

endmodule

// File: rtl/duck_flock_ctrl.sv
// Flock of independent duck channels; slices the packed per-duck buses.
module duck_flock_ctrl
    import duck_pkg::*;
#(
    parameter int unsigned NUM_DUCKS   = 2,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 608,
    parameter int unsigned Y_MIN       = 16,
    parameter int unsigned Y_START     = 300,
    parameter int unsigned STEP_LG     = 4,
    parameter int unsigned STEP_SM     = 2,
    parameter int unsigned FALL_STEP   = 6,
    parameter int unsigned FLAP_FRAMES = 3,
    parameter int unsigned FLY_TICKS   = 64,
    parameter int unsigned SHOT_TICKS  = 5
) (
    input  logic                    ANIM_Clk,
    input  logic                    Reset,
    input  logic [NUM_DUCKS-1:0]    Launch,
    input  logic [NUM_DUCKS-1:0]    Hit,
    input  logic [9:0]              Rand_X,
    input  logic [1:0]              Rand_dir,
    input  logic [1:0]              Rand_color,
    output logic [NUM_DUCKS*10-1:0] Duck_X,
    output logic [NUM_DUCKS*10-1:0] Duck_Y,
    output logic [NUM_DUCKS*6-1:0]  DuckFrame,
    output logic [NUM_DUCKS*2-1:0]  Duck_color,
    output logic [NUM_DUCKS-1:0]    Active,
    output logic [NUM_DUCKS-1:0]    Escaped,
    output logic [NUM_DUCKS-1:0]    Shot_down
);

    // All ducks share the random inputs; staggering is up to the game FSM.
    for (genvar i = 0; i < NUM_DUCKS; i++) begin : g_duck
        duck_flight_fsm #(
            .X_MIN       (X_MIN),
            .X_MAX       (X_MAX),
            .Y_MIN       (Y_MIN),
            .Y_START     (Y_START),
            .STEP_LG     (STEP_LG),
            .STEP_SM     (STEP_SM),
            .FALL_STEP   (FALL_STEP),
            .FLAP_FRAMES (FLAP_FRAMES),
            .FLY_TICKS   (FLY_TICKS),
            .SHOT_TICKS  (SHOT_TICKS)
        ) u_duck (
            .ANIM_Clk   (ANIM_Clk),
            .Reset      (Reset),
            .launch     (Launch[i]),
            .hit        (Hit[i]),
            .rand_x     (Rand_X),
            .rand_dir   (Rand_dir),
            .rand_color (Rand_color),
            .x          (Duck_X[10*i +: 10]),
            .y          (Duck_Y[10*i +: 10]),
            .frame      (DuckFrame[6*i +: 6]),
            .color      (Duck_color[2*i +: 2]),
            .active     (Active[i]),
            .escaped    (Escaped[i]),
            .shot_down  (Shot_down[i])
        );
    end

endmodule

// File: tb/tb_duck_flock_ctrl.sv
// Randomised bench for duck_flock_ctrl with a behavioural per-duck model.
module tb_duck_flock_ctrl;

    localparam int ND          = 2;
    localparam int X_MIN       = 0;
    localparam int X_MAX       = 608;
    localparam int Y_MIN       = 16;
    localparam int Y_START     = 300;
    localparam int STEP_LG     = 4;
    localparam int STEP_SM     = 2;
    localparam int FALL_STEP   = 6;
    localparam int FLAP_FRAMES = 3;
    localparam int FLY_TICKS   = 200;
    localparam int SHOT_TICKS  = 5;

    localparam int MIdle = 0, MLaunch = 1, MFly = 2, MShot = 3, MFall = 4, MEscape = 5, MDone = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ND-1:0]   launch = '0;
    logic [ND-1:0]   hit = '0;
    logic [9:0]      rand_x = '0;
    logic [1:0]      rand_dir = '0;
    logic [1:0]      rand_color = '0;
    logic [ND*10-1:0] duck_x, duck_y;
    logic [ND*6-1:0] duck_frame;
    logic [ND*2-1:0] duck_color;
    logic [ND-1:0]   active, escaped, shot_down;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: one record per duck, stored as parallel arrays.
    int m_mode[ND], m_x[ND], m_y[ND], m_left[ND], m_down[ND], m_shallow[ND];
    int m_col[ND], m_cnt[ND], m_flap[ND], m_ph[ND], m_esc[ND], m_shd[ND];

    int t2_x[5] = '{100, 100, 104, 108, 112};
    int t2_y[5] = '{300, 300, 296, 292, 288};
    int t2_f[5] = '{20, 20, 21, 22, 20};
    int t3_x[4] = '{606, 606, 608, 604};
    int t3_y[4] = '{300, 300, 298, 296};
    int t3_f[4] = '{0, 4, 16, 17};

    always #5 clk = ~clk;

    duck_flock_ctrl #(
        .NUM_DUCKS   (ND),
        .X_MIN       (X_MIN),
        .X_MAX       (X_MAX),
        .Y_MIN       (Y_MIN),
        .Y_START     (Y_START),
        .STEP_LG     (STEP_LG),
        .STEP_SM     (STEP_SM),
        .FALL_STEP   (FALL_STEP),
        .FLAP_FRAMES (FLAP_FRAMES),
        .FLY_TICKS   (FLY_TICKS),
        .SHOT_TICKS  (SHOT_TICKS)
    ) dut (
        .ANIM_Clk   (clk),
        .Reset      (rst),
        .Launch     (launch),
        .Hit        (hit),
        .Rand_X     (rand_x),
        .Rand_dir   (rand_dir),
        .Rand_color (rand_color),
        .Duck_X     (duck_x),
        .Duck_Y     (duck_y),
        .DuckFrame  (duck_frame),
        .Duck_color (duck_color),
        .Active     (active),
        .Escaped    (escaped),
        .Shot_down  (shot_down)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_frame(input int i);
        int c = m_col[i] * 20;
        case (m_mode[i])
            MFly:    return c + (m_left[i] != 0 ? (m_shallow[i] != 0 ? 15 : 11)
                                                : (m_shallow[i] != 0 ? 4 : 0)) + m_flap[i];
            MEscape: return c + (m_left[i] != 0 ? 11 : 0) + m_flap[i];
            MShot:   return c + 8;
            MFall:   return c + 9 + m_ph[i];
            default: return c;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_mode[i] = MIdle; m_x[i] = X_MIN; m_y[i] = Y_START;
            m_left[i] = 0; m_down[i] = 0; m_shallow[i] = 0; m_col[i] = 0;
            m_cnt[i] = 0; m_flap[i] = 0; m_ph[i] = 0; m_esc[i] = 0; m_shd[i] = 0;
        end
    endtask

    // Advance duck i by one tick using the inputs presented at this edge.
    task automatic model_edge(input int i);
        int nx, ny, step, rx;
        m_esc[i] = 0;
        m_shd[i] = 0;
        case (m_mode[i])
            MIdle: if (launch[i]) begin
                rx = int'(rand_x);
                m_x[i] = (rx > X_MAX) ? X_MAX : ((rx < X_MIN) ? X_MIN : rx);
                m_y[i] = Y_START;
                m_left[i] = (rand_dir == 2'd0 || rand_dir == 2'd1) ? 1 : 0;
                m_shallow[i] = (rand_dir == 2'd1 || rand_dir == 2'd3) ? 1 : 0;
                m_down[i] = 0;
                m_col[i] = (rand_color == 2'd3) ? 0 : int'(rand_color);
                m_mode[i] = MLaunch;
            end
            MLaunch: begin
                m_mode[i] = MFly; m_cnt[i] = 0; m_flap[i] = 0;
            end
            MFly: if (hit[i]) begin
                m_mode[i] = MShot; m_cnt[i] = 0;
            end else begin
                nx = m_x[i] + (m_left[i] != 0 ? -STEP_LG : STEP_LG);
                if (nx < X_MIN) begin nx = X_MIN; m_left[i] = 1 - m_left[i]; end
                else if (nx > X_MAX) begin nx = X_MAX; m_left[i] = 1 - m_left[i]; end
                step = (m_shallow[i] != 0) ? STEP_SM : STEP_LG;
                ny = m_y[i] + (m_down[i] != 0 ? step : -step);
                if (ny < Y_MIN) begin ny = Y_MIN; m_down[i] = 1; end
                else if (ny > Y_START) begin ny = Y_START; m_down[i] = 0; end
                m_x[i] = nx; m_y[i] = ny;
                m_cnt[i]++;
                if (m_cnt[i] == FLY_TICKS) begin m_mode[i] = MEscape; m_flap[i] = 0; end
                else m_flap[i] = (m_flap[i] + 1) % FLAP_FRAMES;
            end
            MShot: begin
                m_cnt[i]++;
                if (m_cnt[i] == SHOT_TICKS) begin m_mode[i] = MFall; m_ph[i] = 0; end
            end
            MFall: if (m_y[i] + FALL_STEP >= Y_START) begin
                m_y[i] = Y_START; m_mode[i] = MDone; m_shd[i] = 1;
            end else begin
                m_y[i] += FALL_STEP; m_ph[i] = 1 - m_ph[i];
            end
            MEscape: if (m_y[i] < STEP_LG) begin
                m_mode[i] = MDone; m_esc[i] = 1;
            end else begin
                m_y[i] -= STEP_LG; m_flap[i] = (m_flap[i] + 1) % FLAP_FRAMES;
            end
            default: m_mode[i] = MIdle;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else for (int i = 0; i < ND; i++) model_edge(i);
        #1;
    endtask

    task automatic start(input logic [ND-1:0] mask, input int rx, input int rd, input int rc);
        launch = mask;
        rand_x = 10'(rx);
        rand_dir = 2'(rd);
        rand_color = 2'(rc);
        tick();
        launch = '0;
    endtask

    // Compare every output of every duck against the model, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < ND; i++) begin
                check($sformatf("x[%0d]", i), int'(duck_x[10*i +: 10]), m_x[i]);
                check($sformatf("y[%0d]", i), int'(duck_y[10*i +: 10]), m_y[i]);
                check($sformatf("frame[%0d]", i), int'(duck_frame[6*i +: 6]), exp_frame(i));
                check($sformatf("color[%0d]", i), int'(duck_color[2*i +: 2]), m_col[i]);
                check($sformatf("active[%0d]", i), int'(active[i]), int'(m_mode[i] != MIdle));
                check($sformatf("escaped[%0d]", i), int'(escaped[i]), m_esc[i]);
                check($sformatf("shot_down[%0d]", i), int'(shot_down[i]), m_shd[i]);
            end
        end
    end

    initial begin
        int pulses;
        bit prev;
        model_reset();
        chk_en = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset in mid-flight returns everything to reset values.
        start(2'b01, 200, 2, 1);
        repeat (8) tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_x", int'(duck_x[9:0]), 0);
        check("rst_y", int'(duck_y[9:0]), 300);
        check("rst_frame", int'(duck_frame[5:0]), 0);
        check("rst_color", int'(duck_color[1:0]), 0);
        check("rst_active", int'(active), 0);
        tick();
        rst = 1'b0;

        // NE launch, colour 1: literal trajectory and flap sequence.
        start(2'b01, 100, 2, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            check($sformatf("ne_x%0d", k), int'(duck_x[9:0]), t2_x[k]);
            check($sformatf("ne_y%0d", k), int'(duck_y[9:0]), t2_y[k]);
            check($sformatf("ne_f%0d", k), int'(duck_frame[5:0]), t2_f[k]);
        end
        pulses = 0;
        prev = 1'b0;
        for (int n = 0; n < 600 && m_mode[0] != MIdle; n++) begin
            tick();
            if (prev) check("esc_active_drop", int'(active[0]), 0);
            prev = escaped[0];
            if (escaped[0]) pulses++;
        end
        check("esc_pulses", pulses, 1);
        check("esc_idle", int'(active[0]), 0);

        // E launch near right bound: clamp, heading flips to W frames.
        start(2'b10, 606, 3, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            check($sformatf("e_x%0d", k), int'(duck_x[19:10]), t3_x[k]);
            check($sformatf("e_y%0d", k), int'(duck_y[19:10]), t3_y[k]);
            check($sformatf("e_f%0d", k), int'(duck_frame[11:6]), t3_f[k]);
        end
        for (int n = 0; n < 600 && m_mode[1] != MIdle; n++) tick();
        check("e_idle", int'(active[1]), 0);

        // Hit on the very tick the fly timer expires: hit wins.
        start(2'b01, 300, 1, 1);
        for (int n = 0; n < 300; n++) begin
            if (m_mode[0] == MFly && m_cnt[0] == FLY_TICKS - 1) break;
            tick();
        end
        hit = 2'b01;
        tick();
        hit = '0;
        check("hit_wins_frame", int'(duck_frame[5:0]), 28);
        repeat (4) tick();
        check("shot_hold_frame", int'(duck_frame[5:0]), 28);
        tick();
        check("fall_first_frame", int'(duck_frame[5:0]), 29);
        pulses = 0;
        for (int n = 0; n < 200 && m_mode[0] != MIdle; n++) begin
            tick();
            if (shot_down[0]) begin
                pulses++;
                check("fall_land_y", int'(duck_y[9:0]), 300);
            end
        end
        check("shot_pulses", pulses, 1);
        check("shot_idle", int'(active[0]), 0);

        // Both ducks launched together; only duck 1 is hit.
        start(2'b11, 400, 0, 2);
        repeat (6) tick();
        hit = 2'b10;
        tick();
        hit = '0;
        check("pair_x0", int'(duck_x[9:0]), 376);
        check("pair_x1", int'(duck_x[19:10]), 380);
        check("pair_f0", int'(duck_frame[5:0]), 51);
        check("pair_f1", int'(duck_frame[11:6]), 48);
        for (int n = 0; n < 800 && (m_mode[0] != MIdle || m_mode[1] != MIdle); n++) tick();
        check("pair_idle", int'(active), 0);

        // Random traffic with one asynchronous reset in the middle.
        for (int n = 0; n < 6000; n++) begin
            for (int i = 0; i < ND; i++) begin
                launch[i] = ($urandom_range(0, 5) == 0);
                hit[i] = ($urandom_range(0, 199) == 0);
            end
            rand_x = 10'($urandom_range(0, 1023));
            rand_dir = 2'($urandom_range(0, 3));
            rand_color = 2'($urandom_range(0, 3));
            if (n == 3000) begin
                #2 rst = 1'b1;
                model_reset();
                #1 check("rand_rst_active", int'(active), 0);
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        launch = '0;
        hit = '0;
        repeat (4) tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
